// File: rtl/relprime_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : relprime_ctrl
//  Description : Finds the smallest M >= M_START coprime to N using a
//                subtract-based Euclid loop, behind a start/busy/done
//                handshake. Optional macro RELPRIME_ITER_COUNT_EN adds the
//                iter_count port (GCD subtract steps of the last run).
//  Revision    : 1.0 - initial release
// ============================================================================
module relprime_ctrl #(
  parameter int WIDTH   = 16,
  parameter int M_START = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] n_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
`ifdef RELPRIME_ITER_COUNT_EN
  ,
  output logic [WIDTH-1:0] iter_count
`endif
);

  localparam logic [WIDTH-1:0] c_m_start  = WIDTH'(M_START);
  localparam logic [WIDTH-1:0] c_all_ones = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] c_one      = WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_GCD   = 3'd2,
    S_CHECK = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_n;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic             r_err;

  logic             w_n_zero;
  logic             w_a_eq_b;
  logic             w_a_gt_b;
  logic             w_coprime;
  logic             w_m_last;

  assign w_n_zero  = (n_in == '0);
  assign w_a_eq_b  = (r_a == r_b);
  assign w_a_gt_b  = (r_a > r_b);
  assign w_coprime = (r_a == c_one);
  assign w_m_last  = (r_m == c_all_ones);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = w_n_zero ? S_FIN : S_LOAD;
        end
      end
      S_LOAD:  w_state_nxt = S_GCD;
      S_GCD: begin
        if (w_a_eq_b) begin
          w_state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_coprime || w_m_last) begin
          w_state_nxt = S_FIN;
        end else begin
          w_state_nxt = S_LOAD;
        end
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operands, candidate M and the held result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n      <= '0;
      r_m      <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_n      <= n_in;
            r_m      <= c_m_start;
            r_result <= '0;
            r_err    <= w_n_zero;
          end
        end
        S_LOAD: begin
          r_a <= r_n;
          r_b <= r_m;
        end
        S_GCD: begin
          if (!w_a_eq_b) begin
            if (w_a_gt_b) begin
              r_a <= r_a - r_b;
            end else begin
              r_b <= r_b - r_a;
            end
          end
        end
        S_CHECK: begin
          if (w_coprime) begin
            r_result <= r_m;
          end else if (w_m_last) begin
            // Candidate space exhausted: M would wrap to zero
            r_err    <= 1'b1;
            r_result <= '0;
          end else begin
            r_m <= r_m + c_one;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef RELPRIME_ITER_COUNT_EN
  logic [WIDTH-1:0] r_iter_cnt;
  logic [WIDTH-1:0] r_iter_out;

  // Step counter; the snapshot is taken on the edge entering FIN so it is
  // already valid alongside done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iter_cnt <= '0;
      r_iter_out <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_iter_cnt <= '0;
            if (w_n_zero) begin
              r_iter_out <= '0;
            end
          end
        end
        S_GCD: begin
          if (!w_a_eq_b && (r_iter_cnt != c_all_ones)) begin
            r_iter_cnt <= r_iter_cnt + c_one;
          end
        end
        S_CHECK: begin
          if (w_coprime || w_m_last) begin
            r_iter_out <= r_iter_cnt;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign iter_count = r_iter_out;
`endif

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_FIN);
  assign result = r_result;
  assign err    = r_err;

endmodule
`default_nettype wire
